// File: rtl/sparc_ram_responder.sv
// Memory-side responder for the SPARC control unit RAM interface: big-endian byte
// memory with fixed-latency load/store and a four-phase MFC handshake.
module sparc_ram_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 3
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        MAE
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [5:0]              op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdat_q;
    logic [31:0]             dout_q;
    logic                    mfc_q, mae_q;

    logic [7:0] mem [DEPTH];

    // Upper address bits are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^Address[31:ADDR_WIDTH];

    logic                  is_ld, is_st, sgn, legal, aligned, ok;
    size_e                 sz;
    logic [ADDR_WIDTH-1:0] a1, a2, a3;
    logic [31:0]           rd_word, ld_data;
    logic                  complete, wr_en;

    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        sgn   = 1'b0;
        legal = 1'b1;
        sz    = SZ_WORD;
        case (op_q)
            6'b000000: begin is_ld = 1'b1; sz = SZ_WORD; end
            6'b000001: begin is_ld = 1'b1; sz = SZ_BYTE; end
            6'b000010: begin is_ld = 1'b1; sz = SZ_HALF; end
            6'b001001: begin is_ld = 1'b1; sz = SZ_BYTE; sgn = 1'b1; end
            6'b001010: begin is_ld = 1'b1; sz = SZ_HALF; sgn = 1'b1; end
            6'b000100: begin is_st = 1'b1; sz = SZ_WORD; end
            6'b000101: begin is_st = 1'b1; sz = SZ_BYTE; end
            6'b000110: begin is_st = 1'b1; sz = SZ_HALF; end
            default:   legal = 1'b0;
        endcase
        case (sz)
            SZ_WORD: aligned = (addr_q[1:0] == 2'b00);
            SZ_HALF: aligned = ~addr_q[0];
            default: aligned = 1'b1;
        endcase
        ok = legal & aligned;
    end

    // Byte lanes wrap modulo the decoded address space.
    assign a1 = addr_q + ADDR_WIDTH'(1);
    assign a2 = addr_q + ADDR_WIDTH'(2);
    assign a3 = addr_q + ADDR_WIDTH'(3);
    assign rd_word = {mem[addr_q], mem[a1], mem[a2], mem[a3]};

    always_comb begin
        case (sz)
            SZ_BYTE: ld_data = {{24{sgn & rd_word[31]}}, rd_word[31:24]};
            SZ_HALF: ld_data = {{16{sgn & rd_word[31]}}, rd_word[31:16]};
            default: ld_data = rd_word;
        endcase
    end

    assign complete = (state_q == BUSY) && RAM_enable && (cnt_q == 4'd0);
    assign wr_en    = complete && is_st && ok && !RESET;

    // Memory has no reset; contents survive RESET.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            case (sz)
                SZ_BYTE: mem[addr_q] <= wdat_q[7:0];
                SZ_HALF: begin
                    mem[addr_q] <= wdat_q[15:8];
                    mem[a1]     <= wdat_q[7:0];
                end
                default: begin
                    mem[addr_q] <= wdat_q[31:24];
                    mem[a1]     <= wdat_q[23:16];
                    mem[a2]     <= wdat_q[15:8];
                    mem[a3]     <= wdat_q[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            wdat_q  <= 32'h0;
            dout_q  <= 32'h0;
            mfc_q   <= 1'b0;
            mae_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (RAM_enable) begin
                    op_q    <= RAM_OpCode;
                    addr_q  <= Address[ADDR_WIDTH-1:0];
                    wdat_q  <= DataIn;
                    cnt_q   <= 4'(LATENCY - 1);
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (!RAM_enable) begin
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (is_ld && ok) dout_q <= ld_data;
                        mfc_q   <= 1'b1;
                        mae_q   <= ~ok;
                        state_q <= DONE;
                    end
                end
                DONE: if (!RAM_enable) begin
                    mfc_q   <= 1'b0;
                    mae_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MFC     = mfc_q;
    assign MAE     = mae_q;
endmodule

// File: tb/tb_sparc_ram_responder.sv
// Directed bench for sparc_ram_responder: scoreboard of expected completions,
// checked with immediate assertions when MFC rises.
module tb_sparc_ram_responder;
    localparam int AW  = 9;
    localparam int LAT = 3;

    logic        Clk, RESET, RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] Address, DataIn, DataOut;
    logic        MFC, MAE;

    sparc_ram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .Clk(Clk), .RESET(RESET), .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .MAE(MAE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct { string tag; logic [31:0] d; logic mae; } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    logic [31:0] last_d;

    localparam logic [5:0] LD = 6'b000000, LDUB = 6'b000001, LDUH = 6'b000010,
                           LDSB = 6'b001001, LDSH = 6'b001010, ST = 6'b000100,
                           STB = 6'b000101, STH = 6'b000110, LDD = 6'b000011,
                           STD = 6'b000111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_d, input logic exp_mae);
        int n;
        exp_t e;
        logic [31:0] held;
        sb.push_back('{tag, exp_d, exp_mae});
        @(negedge Clk);
        RAM_enable = 1'b1; RAM_OpCode = op; Address = addr; DataIn = data;
        @(posedge Clk);
        n = 0;
        while (n < 20) begin
            @(posedge Clk); #1;
            n++;
            if (MFC) break;
        end
        e = sb.pop_front();
        check({e.tag, "_lat"}, 32'(n), 32'(LAT));
        check({e.tag, "_data"}, DataOut, e.d);
        check({e.tag, "_mae"}, {31'd0, MAE}, {31'd0, e.mae});
        held = DataOut;
        @(posedge Clk); #1;
        check({e.tag, "_hold"}, {MFC, MAE, DataOut == held}, {1'b1, e.mae, 1'b1});
        @(negedge Clk);
        RAM_enable = 1'b0;
        @(posedge Clk); #1;
        check({e.tag, "_fall"}, {30'd0, MFC, MAE}, 32'd0);
    endtask

    task automatic load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] exp);
        do_req(tag, op, addr, 32'h0, exp, 1'b0);
        last_d = exp;
    endtask

    task automatic store(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] data);
        do_req(tag, op, addr, data, last_d, 1'b0);
    endtask

    task automatic err(input string tag, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] data);
        do_req(tag, op, addr, data, last_d, 1'b1);
    endtask

    initial begin
        logic saw;
        RESET = 1'b1; RAM_enable = 1'b0; RAM_OpCode = 6'd0; Address = 32'h0; DataIn = 32'h0;
        last_d = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_state", {MFC, MAE, DataOut}, 34'h0);
        @(negedge Clk); RESET = 1'b0;

        // Reset mid-access: store must not land, outputs clear at once.
        store("pre_st", ST, 32'h10, 32'h11223344);
        load("pre_ld", LD, 32'h10, 32'h11223344);
        @(negedge Clk);
        RAM_enable = 1'b1; RAM_OpCode = ST; Address = 32'h10; DataIn = 32'hDEADBEEF;
        @(posedge Clk);
        @(posedge Clk); #2;
        RESET = 1'b1;
        #1;
        check("rst_abort", {MFC, MAE, DataOut}, 34'h0);
        last_d = 32'h0;
        @(negedge Clk);
        RESET = 1'b0; RAM_enable = 1'b0;
        load("rst_ld", LD, 32'h10, 32'h11223344);

        // Word round trip and sub-word loads.
        store("st_w", ST, 32'h10, 32'hDEADBEEF);
        load("ld_w", LD, 32'h10, 32'hDEADBEEF);
        load("ldub", LDUB, 32'h11, 32'h000000AD);
        load("ldsb", LDSB, 32'h10, 32'hFFFFFFDE);
        load("lduh", LDUH, 32'h12, 32'h0000BEEF);
        load("ldsh", LDSH, 32'h12, 32'hFFFFBEEF);

        // Sub-word stores.
        store("stb", STB, 32'h13, 32'h00000055);
        load("ld_stb", LD, 32'h10, 32'hDEADBE55);
        store("sth", STH, 32'h10, 32'h00001234);
        load("ld_sth", LD, 32'h10, 32'h1234BE55);

        // Errors: no write, DataOut held, MAE with MFC.
        err("e_ld11", LD, 32'h11, 32'h0);
        err("e_lduh13", LDUH, 32'h13, 32'h0);
        err("e_ldd", LDD, 32'h10, 32'h0);
        err("e_st12", ST, 32'h12, 32'hFFFFFFFF);
        err("e_std", STD, 32'h10, 32'hFFFFFFFF);
        err("e_sth11", STH, 32'h11, 32'hFFFFFFFF);
        load("ld_after_err", LD, 32'h10, 32'h1234BE55);

        // Abort one edge into BUSY.
        store("pre_abort", ST, 32'h20, 32'h55AA55AA);
        @(negedge Clk);
        RAM_enable = 1'b1; RAM_OpCode = ST; Address = 32'h20; DataIn = 32'hCAFEF00D;
        @(posedge Clk);
        @(negedge Clk);
        RAM_enable = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(posedge Clk); #1;
            if (MFC) saw = 1'b1;
        end
        check("abort_mfc", {31'd0, saw}, 32'd0);
        load("ld_abort", LD, 32'h20, 32'h55AA55AA);

        // Address wrap: upper bits ignored.
        store("st_wrap", ST, 32'h200, 32'h01020304);
        load("ld_wrap", LD, 32'h000, 32'h01020304);
        load("ldub_wrap", LDUB, 32'h403, 32'h00000004);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sparc_ram_responder.md
Name: sparc_ram_responder

Overview:
- Memory-side responder for the SPARC control unit's RAM request interface.
- Accepts a request (RAM_enable, RAM_OpCode, address from MAR, store data from MDR) and performs a big-endian byte-addressed load or store after a fixed latency.
- Signals completion on MFC using a four-phase handshake.
- Drives load data, extended per opcode, to the MDR input mux.

Parameters:
- ADDR_WIDTH, 9, byte-address bits actually decoded; memory is 2^ADDR_WIDTH bytes.
- LATENCY, 3, clock edges from request sample to MFC assertion; legal range 1..15.

Ports:
- Clk  input  1  clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-high reset.
- RAM_enable  input  1  request strobe; held high until MFC is seen, then dropped.
- RAM_OpCode  input  6  SPARC op3 field of the load/store instruction.
- Address  input  32  byte address; only bits [ADDR_WIDTH-1:0] are used.
- DataIn  input  32  store data; byte and half stores use the low bits.
- DataOut  output  32  load result, extended per opcode.
- MFC  output  1  memory function complete.
- MAE  output  1  memory access error (misaligned or unsupported opcode); valid while MFC=1.

Behaviour:
- Reset: state IDLE, MFC=0, MAE=0, DataOut=32'h0, latency counter=0. Memory array is not cleared.
- RESET while BUSY aborts the access: no write, MFC low.
- State IDLE: at a posedge with RAM_enable=1, capture opcode, Address[ADDR_WIDTH-1:0] and DataIn into internal registers, load counter with LATENCY-1, go to BUSY. Inputs are not re-sampled after this edge.
- State BUSY, RAM_enable=0 at an edge: abort; go to IDLE with no memory write and no MFC.
- State BUSY, counter!=0: decrement.
- State BUSY, counter==0: perform the access, set MFC=1, set MAE as below, go to DONE.
- MFC therefore rises exactly LATENCY edges after the sample edge.
- State DONE: hold MFC, MAE and DataOut while RAM_enable=1. At the first edge with RAM_enable=0, go to IDLE with MFC=0 and MAE=0.
- A new request needs at least one edge with RAM_enable=0 in between (back-to-back minimum: one idle-return edge).
- Addressing is big-endian: mem[a] supplies word bits [31:24], mem[a+3] supplies bits [7:0]. Addresses wrap modulo 2^ADDR_WIDTH; upper address bits are ignored.
- Opcodes:
  - 000000 ld: word.
  - 000001 ldub: byte, zero-extended.
  - 000010 lduh: half, zero-extended.
  - 001001 ldsb: byte, sign-extended.
  - 001010 ldsh: half, sign-extended.
  - 000100 st: word, writes DataIn[31:0].
  - 000101 stb: writes DataIn[7:0].
  - 000110 sth: writes DataIn[15:0], high byte at a.
- Alignment: word requires a[1:0]=00; half requires a[0]=0. Byte has no requirement.
- Error case (misaligned, or any other opcode including 000011 ldd and 000111 std): no memory write, DataOut unchanged, MAE=1 with MFC=1. The handshake completes normally.
- DataOut updates only at the completion edge of a successful load. Stores leave DataOut unchanged.
- Memory is written only at the completion edge. A store followed by a load of the same location returns the new data.

Test Plan:
- Reset mid-access: assert RESET during BUSY of st 0xDEADBEEF @0x10, then ld @0x10. Required: MFC=0 and DataOut=0 immediately on RESET; the later ld returns the prior contents, not 0xDEADBEEF.
- Word round trip, LATENCY=3: st 0xDEADBEEF @0x10, then ld @0x10. Required: MFC rises on the 3rd edge after the sample edge; DataOut=0xDEADBEEF; MAE=0; MFC falls one edge after RAM_enable drops.
- Sub-word loads after the word store at 0x10:
  - ldub @0x11 → 0x000000AD
  - ldsb @0x10 → 0xFFFFFFDE
  - lduh @0x12 → 0x0000BEEF
  - ldsh @0x12 → 0xFFFFBEEF
- Sub-word stores:
  - stb DataIn=0x00000055 @0x13, then ld @0x10 → 0xDEADBE55.
  - sth DataIn=0x00001234 @0x10, then ld @0x10 → 0x1234BE55.
- Errors: ld @0x11, lduh @0x13 and opcode 000011 @0x10. Required: each gives MFC=1 with MAE=1, DataOut keeps its previous value, and memory @0x10 is unchanged (verified by a following ld).
- Abort and wrap:
  - Drop RAM_enable one edge into BUSY of st 0xCAFEF00D @0x20. Required: no MFC, and ld @0x20 shows the old value.
  - st 0x01020304 @0x200 (ADDR_WIDTH=9). Required: ld @0x000 returns 0x01020304.
